// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
//
// AES-128 key schedule and round-key store. A one-cycle key_load pulse samples
// the cipher key into store entry 0. The schedule then produces one round key
// per clock until all NUM_ROUNDS+1 entries are valid. Decryption reads the same
// entries in reverse order.
//
// Ports
//   clk            in   1       clock, all state updates on rising edge
//   n_rst          in   1       synchronous active-low reset
//   key_load       in   1       pulse: sample key_in and start expansion
//   key_in         in   128     cipher key, w0 = [127:96], byte 0 = [127:120]
//   key_zeroize    in   1       only with AES_KEY_ZEROIZE_EN: wipe store, go idle
//   read_addr      in   ADDR_W  round-key index 0..NUM_ROUNDS
//   round_key_0    out  128     store entry 0 (the cipher key), registered
//   round_key_out  out  128     store[read_addr] (combinational); 0 if out of range
//   key_ready      out  1       all round keys valid and stable
//   busy           out  1       expansion in progress
//
// Build option
//   AES_KEY_ZEROIZE_EN  adds the key_zeroize input. When key_zeroize is high at
//                       an edge it overrides key_load. Without the macro the
//                       store is cleared only by n_rst.
// -----------------------------------------------------------------------------
module aes_key_expander #(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              key_load,
    input  logic [127:0]      key_in,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic              key_zeroize,
`endif
    input  logic [ADDR_W-1:0] read_addr,
    output logic [127:0]      round_key_0,
    output logic [127:0]      round_key_out,
    output logic              key_ready,
    output logic              busy
);

    localparam int         NUM_KEYS   = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward AES S-box
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     round_cnt_q, round_cnt_d;   // index of the entry written next
    logic [127:0]   work_key_q, work_key_d;     // last key produced (input to next round)
    logic [127:0]   key_store_q [0:NUM_KEYS-1];
    logic [127:0]   key_store_d [0:NUM_KEYS-1];

    logic           zeroize;
    logic [7:0]     rcon;
    logic [31:0]    rot_w;
    logic [31:0]    sub_w;
    logic [127:0]   next_key;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize = key_zeroize;
`else
    assign zeroize = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // One round of the key schedule, computed from the previous round key
    // -------------------------------------------------------------------------
    always_comb begin
        rcon = 8'h00;
        case (round_cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord of w3: byte rotate left by one
    assign rot_w = {work_key_q[23:0], work_key_q[31:24]};

    // SubWord: four parallel S-box lookups
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_w[gi*8 +: 8] = SBOX[rot_w[gi*8 +: 8]];
        end
    endgenerate

    always_comb begin
        logic [31:0] t_w;
        logic [31:0] n0, n1, n2, n3;
        t_w      = sub_w ^ {rcon, 24'h000000};
        n0       = work_key_q[127:96] ^ t_w;
        n1       = work_key_q[95:64]  ^ n0;
        n2       = work_key_q[63:32]  ^ n1;
        n3       = work_key_q[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Zeroize beats load; a load restarts from any state,
    // including on the edge that would otherwise finish the expansion.
    always_comb begin
        state_d = state_q;
        if (zeroize) begin
            state_d = IDLE;
        end else if (key_load) begin
            state_d = EXPAND;
        end else if ((state_q == EXPAND) && (round_cnt_q == LAST_ROUND)) begin
            state_d = READY;
        end
    end

    // FSM: outputs, decoded from the registered state so busy and key_ready
    // can never be high together
    always_comb begin
        busy      = (state_q == EXPAND);
        key_ready = (state_q == READY);
    end

    // -------------------------------------------------------------------------
    // Counter, working key and store
    // -------------------------------------------------------------------------
    always_comb begin
        round_cnt_d = round_cnt_q;
        work_key_d  = work_key_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_store_d[i] = key_store_q[i];
        end

        if (zeroize) begin
            round_cnt_d = 4'd0;
            work_key_d  = '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_store_d[i] = '0;
            end
        end else if (key_load) begin
            // Entries 1..N keep stale contents until overwritten; readers gate
            // on key_ready.
            key_store_d[0] = key_in;
            work_key_d     = key_in;
            round_cnt_d    = 4'd1;
        end else if (state_q == EXPAND) begin
            for (int i = 1; i < NUM_KEYS; i++) begin
                if (round_cnt_q == 4'(i)) begin
                    key_store_d[i] = next_key;
                end
            end
            work_key_d = next_key;
            if (round_cnt_q != LAST_ROUND) begin
                round_cnt_d = round_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            round_cnt_q <= 4'd0;
            work_key_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_store_q[i] <= '0;
            end
        end else begin
            round_cnt_q <= round_cnt_d;
            work_key_q  <= work_key_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_store_q[i] <= key_store_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    assign round_key_0 = key_store_q[0];

    // Out-of-range addresses fall through to zero
    always_comb begin
        round_key_out = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (read_addr == ADDR_W'(i)) begin
                round_key_out = key_store_q[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              key_load;
    logic [127:0]      key_in;
    logic [ADDR_W-1:0] read_addr;
    logic [127:0]      round_key_0;
    logic [127:0]      round_key_out;
    logic              key_ready;
    logic              busy;
`ifdef AES_KEY_ZEROIZE_EN
    logic              key_zeroize;
`endif

    aes_key_expander #(
        .NUM_ROUNDS (10),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .key_load      (key_load),
        .key_in        (key_in),
`ifdef AES_KEY_ZEROIZE_EN
        .key_zeroize   (key_zeroize),
`endif
        .read_addr     (read_addr),
        .round_key_0   (round_key_0),
        .round_key_out (round_key_out),
        .key_ready     (key_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           addr;
        logic [127:0] key;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] sbox_m [0:255];

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A    = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] KEY_B    = 128'h55aa55aa0f0f0f0f3c3c3c3cc3c3c3c3;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-wise key expansion; pushes the 11 expected round keys
    task automatic push_schedule(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t  = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            e.addr = r;
            e.key  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            sb_q.push_back(e);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Count edges after the load edge until key_ready; bounded
    task automatic wait_ready(input string tag);
        int n;
        int both;
        n    = 0;
        both = 0;
        while (!key_ready && n < 20) begin
            tick();
            n++;
            if (busy && key_ready) both++;
        end
        check_val({tag, "_latency"}, 128'(n), 128'd10);
        check_val({tag, "_busy_low"}, 128'(busy), 128'd0);
        check_val({tag, "_mutex"}, 128'(both), 128'd0);
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e         = sb_q.pop_front();
            read_addr = ADDR_W'(e.addr);
            #1;
            check_val($sformatf("%s_k%0d", tag, e.addr), round_key_out, e.key);
        end
    endtask

    task automatic read_at(input string tag, input int a, input logic [127:0] exp);
        read_addr = ADDR_W'(a);
        #1;
        check_val(tag, round_key_out, exp);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_busy"}, 128'(busy), 128'd0);
        check_val({tag, "_ready"}, 128'(key_ready), 128'd0);
        check_val({tag, "_rk0"}, round_key_0, 128'h0);
        for (int a = 0; a < 11; a++) read_at($sformatf("%s_zero%0d", tag, a), a, 128'h0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_rst     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        read_addr = '0;
`ifdef AES_KEY_ZEROIZE_EN
        key_zeroize = 1'b0;
`endif
        build_sbox();

        // Reset, with a load attempt that must be ignored
        tick();
        key_in   = KEY_FIPS;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check_cleared("rst");
        n_rst = 1'b1;
        tick();
        check_val("rst_idle_busy", 128'(busy), 128'd0);

        // FIPS-197 vector
        push_schedule(KEY_FIPS);
        load_key(KEY_FIPS);
        check_val("fips_busy", 128'(busy), 128'd1);
        check_val("fips_ready_low", 128'(key_ready), 128'd0);
        wait_ready("fips");
        check_val("fips_rk0", round_key_0, KEY_FIPS);
        read_at("fips_const1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_at("fips_const10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain_sb("fips");

        // Sequential key, out-of-range reads, hold in READY
        push_schedule(KEY_SEQ);
        load_key(KEY_SEQ);
        wait_ready("seq");
        read_at("seq_const10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_at("seq_addr11", 11, 128'h0);
        read_at("seq_addr31", 31, 128'h0);
        drain_sb("seq");
        repeat (6) tick();
        read_at("seq_hold10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check_val("seq_hold_ready", 128'(key_ready), 128'd1);

        // Restart mid-expansion: B loaded on edge 4 after A
        push_schedule(KEY_A);
        load_key(KEY_A);
        repeat (3) tick();
        check_val("rs_mid_ready", 128'(key_ready), 128'd0);
        sb_q.delete();
        push_schedule(KEY_B);
        load_key(KEY_B);
        wait_ready("rs");
        drain_sb("rs");

        // Restart on the completing edge: load wins
        push_schedule(KEY_B);
        load_key(KEY_B);
        repeat (9) tick();
        sb_q.delete();
        push_schedule(KEY_A);
        load_key(KEY_A);
        check_val("last_edge_busy", 128'(busy), 128'd1);
        check_val("last_edge_ready", 128'(key_ready), 128'd0);
        wait_ready("last_edge");
        drain_sb("last_edge");

        // Reset on edge 5 of an expansion
        push_schedule(KEY_SEQ);
        load_key(KEY_SEQ);
        repeat (4) tick();
        n_rst = 1'b0;
        tick();
        sb_q.delete();
        check_cleared("midrst");
        n_rst = 1'b1;
        push_schedule(KEY_FIPS);
        load_key(KEY_FIPS);
        wait_ready("after_rst");
        drain_sb("after_rst");

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize overrides a simultaneous load
        key_zeroize = 1'b1;
        key_in      = KEY_A;
        key_load    = 1'b1;
        tick();
        key_zeroize = 1'b0;
        key_load    = 1'b0;
        check_cleared("zero");
        repeat (3) tick();
        check_val("zero_stays_idle", 128'(busy), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
